// File: rtl/mem_stream_writer.sv
// Streams signed results over a valid/ready handshake into a burst of memory writes.
// The burst base and length are programmable. Out-of-range writes either wrap or abort the burst.
module mem_stream_writer #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int MEM_SIZE     = 64,
  parameter bit WRAP_EN      = 1'b1,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH:0]     cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RESULT_WIDTH-1:0] data_in,
  output logic                    write_en,
  output logic [ADDR_WIDTH-1:0]   write_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH:0]     words_written
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    past_end_q, past_end_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   conv_data;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    out_of_range;

  generate
    if (RESULT_WIDTH > DATA_WIDTH) begin : g_narrow
      if (SATURATE) begin : g_sat
        // The value fits when every bit from the new sign position upward agrees.
        logic [RESULT_WIDTH-DATA_WIDTH:0] top_bits;
        assign top_bits = data_in[RESULT_WIDTH-1:DATA_WIDTH-1];
        always_comb begin
          if (top_bits == '0 || top_bits == '1) conv_data = data_in[DATA_WIDTH-1:0];
          else if (data_in[RESULT_WIDTH-1])      conv_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
          else                                   conv_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
      end else begin : g_trunc
        assign conv_data = data_in[DATA_WIDTH-1:0];
      end
    end else if (RESULT_WIDTH == DATA_WIDTH) begin : g_same
      assign conv_data = data_in;
    end else begin : g_sext
      assign conv_data = {{(DATA_WIDTH-RESULT_WIDTH){data_in[RESULT_WIDTH-1]}}, data_in};
    end
  endgenerate

  assign next_addr = (WRAP_EN && addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  // past_end_q catches the ADDR_WIDTH roll-over that a plain compare would miss.
  assign out_of_range = !WRAP_EN && (past_end_q || ({1'b0, addr_q} >= MEM_LIMIT));

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    past_end_d = past_end_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    dout_d     = dout_q;
    done_d     = (state_q == DONE);
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = cfg_base;
          len_d      = cfg_len;
          cnt_d      = '0;
          err_d      = 1'b0;
          past_end_d = 1'b0;
          state_d    = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (out_of_range) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            dout_d  = conv_data;
            cnt_d   = cnt_q + 1'b1;
            addr_d  = next_addr;
            if (!WRAP_EN && addr_q == LAST_ADDR) past_end_d = 1'b1;
            if (cnt_d == len_q) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      past_end_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      past_end_q <= past_end_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready      = (state_q == RUN);
  assign busy          = (state_q == RUN);
  assign write_en      = we_q;
  assign write_address = waddr_q;
  assign data_out      = dout_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_mem_stream_writer.sv
// Directed bench for mem_stream_writer: four instances cover wrap/abort and 24->16 saturate/truncate.
// All instances share stimulus; each scenario task checks the instances it cares about.
module tb_mem_stream_writer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [5:0]  cfg_base;
  logic [6:0]  cfg_len;
  logic [23:0] data_in;

  logic a_rdy, a_we, a_busy, a_done, a_err;
  logic [5:0] a_addr; logic [15:0] a_dout; logic [6:0] a_ww;
  logic w_rdy, w_we, w_busy, w_done, w_err;
  logic [5:0] w_addr; logic [15:0] w_dout; logic [6:0] w_ww;
  logic s1_rdy, s1_we, s1_busy, s1_done, s1_err;
  logic [5:0] s1_addr; logic [15:0] s1_dout; logic [6:0] s1_ww;
  logic s0_rdy, s0_we, s0_busy, s0_done, s0_err;
  logic [5:0] s0_addr; logic [15:0] s0_dout; logic [6:0] s0_ww;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stream_writer #(.WRAP_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(a_rdy), .data_in(data_in[15:0]), .write_en(a_we),
    .write_address(a_addr), .data_out(a_dout), .busy(a_busy), .done(a_done), .err(a_err),
    .words_written(a_ww));

  mem_stream_writer #(.WRAP_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(w_rdy), .data_in(data_in[15:0]), .write_en(w_we),
    .write_address(w_addr), .data_out(w_dout), .busy(w_busy), .done(w_done), .err(w_err),
    .words_written(w_ww));

  mem_stream_writer #(.RESULT_WIDTH(24), .SATURATE(1'b1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(s1_rdy), .data_in(data_in), .write_en(s1_we),
    .write_address(s1_addr), .data_out(s1_dout), .busy(s1_busy), .done(s1_done), .err(s1_err),
    .words_written(s1_ww));

  mem_stream_writer #(.RESULT_WIDTH(24), .SATURATE(1'b0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(s0_rdy), .data_in(data_in), .write_en(s0_we),
    .write_address(s0_addr), .data_out(s0_dout), .busy(s0_busy), .done(s0_done), .err(s0_err),
    .words_written(s0_ww));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] b, input logic [6:0] l);
    start = 1'b1; cfg_base = b; cfg_len = l;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; data_in = '0; cfg_base = 6'd5; cfg_len = 7'd3;
    step(); step();
    n_vec++;
    if ({a_we, a_addr, a_dout, a_done, a_err, a_ww, a_rdy, a_busy} !== 35'd0) begin
      n_err++; $display("FAIL reset_a: got %h want 0", {a_we, a_addr, a_dout, a_done, a_err, a_ww, a_rdy, a_busy});
    end
    n_vec++;
    if ({w_we, w_addr, w_dout, w_done, w_err, w_ww, w_rdy, w_busy} !== 35'd0) begin
      n_err++; $display("FAIL reset_w: got %h want 0", {w_we, w_addr, w_dout, w_done, w_err, w_ww, w_rdy, w_busy});
    end
    n_vec++;
    if ({s1_we, s1_addr, s1_dout, s1_done, s1_err, s1_ww, s1_rdy, s1_busy,
         s0_we, s0_addr, s0_dout, s0_done, s0_err, s0_ww, s0_rdy, s0_busy} !== 70'd0) begin
      n_err++; $display("FAIL reset_s: got %h/%h want 0",
        {s1_we, s1_addr, s1_dout, s1_done, s1_err, s1_ww, s1_rdy, s1_busy},
        {s0_we, s0_addr, s0_dout, s0_done, s0_err, s0_ww, s0_rdy, s0_busy});
    end
    rst = 1'b0; start = 1'b0;
    step();
    n_vec++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored: busy got %b want 0", a_busy); end
  endtask

  task automatic test_back_to_back();
    pulse_start(6'd4, 7'd3);
    n_vec++;
    if ({a_rdy, a_busy} !== 2'b11) begin n_err++; $display("FAIL b2b_run: rdy/busy got %b want 11", {a_rdy, a_busy}); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; data_in = 24'(10 * (i + 1));
      step();
      n_vec++;
      if ({a_we, a_addr, a_dout, a_ww} !== {1'b1, 6'(4 + i), 16'(10 * (i + 1)), 7'(i + 1)}) begin
        n_err++; $display("FAIL b2b_write[%0d]: we/addr/data/ww got %b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
          i, a_we, a_addr, a_dout, a_ww, 4 + i, 10 * (i + 1), i + 1);
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if ({a_rdy, a_busy, a_done} !== 3'b000) begin n_err++; $display("FAIL b2b_end: rdy/busy/done got %b want 000", {a_rdy, a_busy, a_done}); end
    step();
    n_vec++;
    if ({a_done, a_we} !== 2'b10) begin n_err++; $display("FAIL b2b_done: done/we got %b want 10", {a_done, a_we}); end
    step();
    n_vec++;
    if ({a_done, a_ww, a_err} !== {1'b0, 7'd3, 1'b0}) begin
      n_err++; $display("FAIL b2b_after: done/ww/err got %b/%0d/%b want 0/3/0", a_done, a_ww, a_err);
    end
  endtask

  task automatic test_valid_toggle();
    logic [4:0] pat;
    int k;
    pat = 5'b10101;
    k = 0;
    pulse_start(6'd4, 7'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i]; data_in = pat[i] ? 24'(10 * (k + 1)) : 24'h00DEAD;
      step();
      n_vec++;
      if (pat[i]) begin
        if ({a_we, a_addr, a_dout} !== {1'b1, 6'(4 + k), 16'(10 * (k + 1))}) begin
          n_err++; $display("FAIL toggle_write[%0d]: we/addr/data got %b/%0d/%0d want 1/%0d/%0d",
            i, a_we, a_addr, a_dout, 4 + k, 10 * (k + 1));
        end
        k++;
      end else begin
        if ({a_we, a_ww, a_rdy} !== {1'b0, 7'(k), 1'b1}) begin
          n_err++; $display("FAIL toggle_idle[%0d]: we/ww/rdy got %b/%0d/%b want 0/%0d/1", i, a_we, a_ww, a_rdy, k);
        end
      end
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({a_done, a_ww} !== {1'b1, 7'd3}) begin n_err++; $display("FAIL toggle_done: done/ww got %b/%0d want 1/3", a_done, a_ww); end
    step();
  endtask

  task automatic test_wrap_abort();
    logic [5:0] exp_a [4];
    exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
    pulse_start(6'd62, 7'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; data_in = 24'(100 + i);
      step();
      n_vec++;
      if ({a_we, a_addr, a_dout} !== {1'b1, exp_a[i], 16'(100 + i)}) begin
        n_err++; $display("FAIL wrap_write[%0d]: we/addr/data got %b/%0d/%0d want 1/%0d/%0d",
          i, a_we, a_addr, a_dout, exp_a[i], 100 + i);
      end
      n_vec++;
      if (i < 2) begin
        if ({w_we, w_addr, w_dout, w_err} !== {1'b1, exp_a[i], 16'(100 + i), 1'b0}) begin
          n_err++; $display("FAIL abort_write[%0d]: we/addr/data/err got %b/%0d/%0d/%b want 1/%0d/%0d/0",
            i, w_we, w_addr, w_dout, w_err, exp_a[i], 100 + i);
        end
      end else if (i == 2) begin
        if ({w_we, w_err, w_rdy, w_done} !== 4'b0100) begin
          n_err++; $display("FAIL abort_hit: we/err/rdy/done got %b want 0100", {w_we, w_err, w_rdy, w_done});
        end
      end else begin
        if ({w_we, w_err, w_done} !== 3'b011) begin
          n_err++; $display("FAIL abort_done: we/err/done got %b want 011", {w_we, w_err, w_done});
        end
      end
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({a_done, a_err, a_ww} !== {1'b1, 1'b0, 7'd4}) begin
      n_err++; $display("FAIL wrap_end: done/err/ww got %b/%b/%0d want 1/0/4", a_done, a_err, a_ww);
    end
    n_vec++;
    if ({w_done, w_err, w_ww} !== {1'b0, 1'b1, 7'd2}) begin
      n_err++; $display("FAIL abort_end: done/err/ww got %b/%b/%0d want 0/1/2", w_done, w_err, w_ww);
    end
    step();
  endtask

  task automatic test_saturate();
    logic [23:0] vin  [6];
    logic [15:0] exp1 [6];
    logic [15:0] exp0 [6];
    vin  = '{24'h7FFFFF, 24'h800000, 24'h000123, 24'hFFFF80, 24'hFF7FFF, 24'h008000};
    exp1 = '{16'h7FFF,   16'h8000,   16'h0123,   16'hFF80,   16'h8000,   16'h7FFF};
    exp0 = '{16'hFFFF,   16'h0000,   16'h0123,   16'hFF80,   16'h7FFF,   16'h8000};
    pulse_start(6'd0, 7'd6);
    n_vec++;
    if (w_err !== 1'b0) begin n_err++; $display("FAIL err_cleared_on_start: got %b want 0", w_err); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; data_in = vin[i];
      step();
      n_vec++;
      if ({s1_we, s1_dout} !== {1'b1, exp1[i]}) begin
        n_err++; $display("FAIL sat_on[%0d]: we/data got %b/%h want 1/%h", i, s1_we, s1_dout, exp1[i]);
      end
      n_vec++;
      if ({s0_we, s0_dout} !== {1'b1, exp0[i]}) begin
        n_err++; $display("FAIL sat_off[%0d]: we/data got %b/%h want 1/%h", i, s0_we, s0_dout, exp0[i]);
      end
    end
    in_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_zero_len_and_ignored_start();
    pulse_start(6'd10, 7'd0);
    in_valid = 1'b1; data_in = 24'd5;
    n_vec++;
    if ({a_rdy, a_busy, a_we} !== 3'b000) begin n_err++; $display("FAIL zlen_state: rdy/busy/we got %b want 000", {a_rdy, a_busy, a_we}); end
    step();
    n_vec++;
    if ({a_done, a_rdy, a_we} !== 3'b100) begin n_err++; $display("FAIL zlen_done: done/rdy/we got %b want 100", {a_done, a_rdy, a_we}); end
    step();
    n_vec++;
    if ({a_done, a_rdy, a_we, a_ww} !== 10'd0) begin
      n_err++; $display("FAIL zlen_after: done/rdy/we/ww got %b/%b/%b/%0d want 0/0/0/0", a_done, a_rdy, a_we, a_ww);
    end
    in_valid = 1'b0;
    pulse_start(6'd20, 7'd2);
    in_valid = 1'b1; data_in = 24'd7;
    start = 1'b1; cfg_base = 6'd40; cfg_len = 7'd5;
    step();
    start = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_dout} !== {1'b1, 6'd20, 16'd7}) begin
      n_err++; $display("FAIL midstart_w0: we/addr/data got %b/%0d/%0d want 1/20/7", a_we, a_addr, a_dout);
    end
    data_in = 24'd8;
    step();
    n_vec++;
    if ({a_we, a_addr, a_dout} !== {1'b1, 6'd21, 16'd8}) begin
      n_err++; $display("FAIL midstart_w1: we/addr/data got %b/%0d/%0d want 1/21/8", a_we, a_addr, a_dout);
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({a_done, a_ww} !== {1'b1, 7'd2}) begin n_err++; $display("FAIL midstart_done: done/ww got %b/%0d want 1/2", a_done, a_ww); end
    step();
    n_vec++;
    if ({a_busy, a_done} !== 2'b00) begin n_err++; $display("FAIL midstart_idle: busy/done got %b want 00", {a_busy, a_done}); end
  endtask

  task automatic test_reset_mid_burst();
    pulse_start(6'd8, 7'd5);
    in_valid = 1'b1; data_in = 24'd1;
    step();
    data_in = 24'd2;
    step();
    n_vec++;
    if ({a_addr, a_ww} !== {6'd9, 7'd2}) begin n_err++; $display("FAIL rstmid_pre: addr/ww got %0d/%0d want 9/2", a_addr, a_ww); end
    data_in = 24'd3; rst = 1'b1;
    step();
    n_vec++;
    if ({a_we, a_addr, a_dout, a_done, a_err, a_ww, a_rdy, a_busy} !== 35'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h want 0", {a_we, a_addr, a_dout, a_done, a_err, a_ww, a_rdy, a_busy});
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    n_vec++;
    if ({a_busy, a_we} !== 2'b00) begin n_err++; $display("FAIL rstmid_idle: busy/we got %b want 00", {a_busy, a_we}); end
    pulse_start(6'd0, 7'd1);
    in_valid = 1'b1; data_in = 24'h000055;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_dout, a_ww, a_rdy} !== {1'b1, 6'd0, 16'h0055, 7'd1, 1'b0}) begin
      n_err++; $display("FAIL rstmid_single: we/addr/data/ww/rdy got %b/%0d/%h/%0d/%b want 1/0/0055/1/0",
        a_we, a_addr, a_dout, a_ww, a_rdy);
    end
    step();
    n_vec++;
    if ({a_done, a_we} !== 2'b10) begin n_err++; $display("FAIL rstmid_done: done/we got %b want 10", {a_done, a_we}); end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_wrap_abort();
    test_saturate();
    test_zero_len_and_ignored_start();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
